// File: rtl/game_walk_ctrl_pkg.sv
// Shared definitions for the walk controller: state field slices, board
// border coordinates and the controller FSM encoding.
package game_walk_ctrl_pkg;

    localparam int STATE_W = 134;
    localparam int WAY_MSB = 133;
    localparam int WAY_LSB = 70;
    localparam int BOX_MSB = 69;
    localparam int BOX_LSB = 6;
    localparam int MAN_W   = 6;

    localparam logic [2:0] BORDER_LO = 3'd0;
    localparam logic [2:0] BORDER_HI = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_WIN  = 2'd2
    } walk_state_t;

    // A cell on the outer ring is never a legal walk target.
    function automatic logic on_border(input logic [MAN_W-1:0] pos);
        return (pos[2:0] == BORDER_LO) || (pos[2:0] == BORDER_HI) ||
               (pos[5:3] == BORDER_LO) || (pos[5:3] == BORDER_HI);
    endfunction

endpackage

// File: rtl/game_walk_ctrl_pace_timer.sv
// Step pacing down-counter: reloads to STEP_DIV-1 and raises tick for one
// cycle whenever it sits at zero while running.
module game_pace_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] count;

    // Count down while running; a reload always wins so each step restarts cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (reload) begin
            count <= RELOAD_VAL;
        end else if (run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tick = run && (count == '0);

endmodule

// File: rtl/game_walk_ctrl.sv
// Walk controller: holds the committed game state, accepts clicks and steps
// the external mover toward the clicked cell at a paced rate.
module game_walk_ctrl
    import game_walk_ctrl_pkg::*;
#(
    parameter int STEP_DIV   = 4,
    parameter int WALK_LIMIT = 16,
    parameter int STEP_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [STATE_W-1:0] level_state,
    input  logic [63:0]        level_goal,
    input  logic               click_valid,
    input  logic [MAN_W-1:0]   click_pos,
    output logic               click_ready,
    output logic [STATE_W-1:0] mv_state,
    output logic [MAN_W-1:0]   mv_cursor,
    input  logic [STATE_W-1:0] mv_next,
    input  logic               mv_result,
    output logic [STATE_W-1:0] game_state,
    output logic               busy,
    output logic               blocked,
    output logic               win,
    output logic [STEP_W-1:0]  step_count
);

    localparam int WC_W = $clog2(WALK_LIMIT + 1);
    localparam logic [WC_W-1:0] LAST_STEP = WC_W'(WALK_LIMIT - 1);

    walk_state_t        state_q;
    logic [STATE_W-1:0] game_state_q;
    logic [63:0]        goal_q;
    logic [MAN_W-1:0]   cursor_q;
    logic [STEP_W-1:0]  step_count_q;
    logic [WC_W-1:0]    walk_cnt_q;
    logic               loaded_q;
    logic               blocked_q;

    logic [MAN_W-1:0]   man;
    logic [63:0]        box;
    logic               win_c;
    logic               ready_c;
    logic               click_ok;
    logic               walking;
    logic               step_tick;
    logic               timer_reload;

    assign man      = game_state_q[MAN_W-1:0];
    assign box      = game_state_q[BOX_MSB:BOX_LSB];
    assign win_c    = loaded_q && (box == goal_q) && (goal_q != '0);
    assign ready_c  = loaded_q && (state_q == ST_IDLE) && !win_c;
    assign click_ok = click_valid && ready_c && (click_pos != man) && !on_border(click_pos);
    assign walking  = (state_q == ST_WALK);

    assign timer_reload = !load && (click_ok || step_tick);

    game_pace_timer #(
        .STEP_DIV(STEP_DIV)
    ) u_pace (
        .clk   (clk),
        .rst   (rst),
        .reload(timer_reload),
        .run   (walking),
        .tick  (step_tick)
    );

    // Main controller: load/reset handling, click acceptance, step commit and win latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            game_state_q <= '0;
            goal_q       <= '0;
            cursor_q     <= '0;
            step_count_q <= '0;
            walk_cnt_q   <= '0;
            loaded_q     <= 1'b0;
            blocked_q    <= 1'b0;
        end else if (load) begin
            state_q      <= ST_IDLE;
            game_state_q <= level_state;
            goal_q       <= level_goal;
            step_count_q <= '0;
            walk_cnt_q   <= '0;
            loaded_q     <= 1'b1;
            blocked_q    <= 1'b0;
        end else begin
            blocked_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (win_c) begin
                        state_q <= ST_WIN;
                    end else if (click_ok) begin
                        cursor_q   <= click_pos;
                        walk_cnt_q <= '0;
                        state_q    <= ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (win_c) begin
                        state_q <= ST_WIN;
                    end else if (step_tick) begin
                        if (mv_result) begin
                            game_state_q <= mv_next;
                            walk_cnt_q   <= walk_cnt_q + 1'b1;
                            if (step_count_q != '1) begin
                                step_count_q <= step_count_q + 1'b1;
                            end
                            if (mv_next[MAN_W-1:0] == cursor_q) begin
                                state_q <= ST_IDLE;
                            end else if (walk_cnt_q == LAST_STEP) begin
                                state_q   <= ST_IDLE;
                                blocked_q <= 1'b1;
                            end
                        end else begin
                            state_q   <= ST_IDLE;
                            blocked_q <= 1'b1;
                        end
                    end
                end
                ST_WIN: begin
                    state_q <= ST_WIN;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign click_ready = ready_c;
    assign mv_state    = game_state_q;
    assign mv_cursor   = cursor_q;
    assign game_state  = game_state_q;
    assign busy        = walking;
    assign blocked     = blocked_q;
    assign win         = win_c;
    assign step_count  = step_count_q;

endmodule

// File: tb/tb_game_walk_ctrl.sv
// Bench for game_walk_ctrl: a sokoban-style mover model drives the DUT and a
// step-by-step reference of the controller rules is compared every cycle.
module tb_game_walk_ctrl;

    localparam int DIV      = 4;
    localparam int LIMIT    = 16;
    localparam int SW       = 8;
    localparam int STEP_MAX = (1 << SW) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [133:0] level_state;
    logic [63:0]  level_goal;
    logic         click_valid;
    logic [5:0]   click_pos;
    logic         click_ready;
    logic [133:0] mv_state;
    logic [5:0]   mv_cursor;
    logic [133:0] mv_next;
    logic         mv_result;
    logic [133:0] game_state;
    logic         busy;
    logic         blocked;
    logic         win;
    logic [SW-1:0] step_count;

    bit osc_mode = 1'b0;

    int compared = 0;
    int failed   = 0;

    logic [133:0] m_state;
    logic [63:0]  m_goal;
    logic [5:0]   m_cursor;
    int           m_steps, m_walk_n, m_timer;
    bit           m_loaded, m_walking, m_won, m_blocked;
    bit           m_valid = 1'b0;

    game_walk_ctrl #(
        .STEP_DIV  (DIV),
        .WALK_LIMIT(LIMIT),
        .STEP_W    (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .level_state(level_state),
        .level_goal (level_goal),
        .click_valid(click_valid),
        .click_pos  (click_pos),
        .click_ready(click_ready),
        .mv_state   (mv_state),
        .mv_cursor  (mv_cursor),
        .mv_next    (mv_next),
        .mv_result  (mv_result),
        .game_state (game_state),
        .busy       (busy),
        .blocked    (blocked),
        .win        (win),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    // Mover: one step toward the cursor (x first), pushing at most one box.
    // In oscillating mode it just flips the man's x LSB and never fails.
    function automatic logic [134:0] mover(input logic [133:0] s, input logic [5:0] cur, input bit osc);
        logic [63:0] way, bx;
        int x, y, cx, cy, dx, dy, tx, ty, ux, uy, t, u;
        way = s[133:70];
        bx  = s[69:6];
        x = int'(s[2:0]);  y = int'(s[5:3]);
        cx = int'(cur[2:0]); cy = int'(cur[5:3]);
        if (osc) return {1'b1, way, bx, s[5:3], s[2:1], ~s[0]};
        dx = 0; dy = 0;
        if (cx > x) dx = 1;
        else if (cx < x) dx = -1;
        else if (cy > y) dy = 1;
        else if (cy < y) dy = -1;
        else return {1'b0, s};
        tx = x + dx; ty = y + dy;
        if (tx < 0 || tx > 7 || ty < 0 || ty > 7) return {1'b0, s};
        t = ty * 8 + tx;
        if (!way[t]) return {1'b0, s};
        if (!bx[t]) return {1'b1, way, bx, 6'(t)};
        ux = tx + dx; uy = ty + dy;
        if (ux < 0 || ux > 7 || uy < 0 || uy > 7) return {1'b0, s};
        u = uy * 8 + ux;
        if (!way[u] || bx[u]) return {1'b0, s};
        bx[t] = 1'b0;
        bx[u] = 1'b1;
        return {1'b1, way, bx, 6'(t)};
    endfunction

    always_comb begin
        {mv_result, mv_next} = mover(mv_state, mv_cursor, osc_mode);
    end

    function automatic bit model_win();
        return m_loaded && (m_state[69:6] == m_goal) && (m_goal != 64'd0);
    endfunction

    function automatic bit legal_target(input logic [5:0] p, input logic [5:0] man);
        return (p != man) && (p[2:0] != 3'd0) && (p[2:0] != 3'd7) &&
               (p[5:3] != 3'd0) && (p[5:3] != 3'd7);
    endfunction

    function automatic logic [63:0] cells(input int y, input int x0, input int x1);
        logic [63:0] m;
        m = 64'd0;
        for (int x = x0; x <= x1; x++) m[y * 8 + x] = 1'b1;
        return m;
    endfunction

    // Reference: what the controller must do on each rising edge.
    always @(posedge clk) begin : ref_model
        logic [134:0] mr;
        bit mwin, mready;
        mwin   = model_win();
        mready = m_loaded && !m_walking && !m_won && !mwin;
        if (rst) begin
            m_state = '0; m_goal = '0; m_cursor = '0;
            m_steps = 0; m_walk_n = 0; m_timer = 0;
            m_loaded = 0; m_walking = 0; m_won = 0; m_blocked = 0;
        end else if (load) begin
            m_state = level_state; m_goal = level_goal;
            m_steps = 0; m_walk_n = 0;
            m_loaded = 1; m_walking = 0; m_won = 0; m_blocked = 0;
        end else begin
            m_blocked = 0;
            if (!m_won && mwin) begin
                m_won = 1;
                m_walking = 0;
            end else if (m_walking) begin
                if (m_timer == 0) begin
                    mr = mover(m_state, m_cursor, osc_mode);
                    if (mr[134]) begin
                        m_state = mr[133:0];
                        if (m_steps < STEP_MAX) m_steps++;
                        m_walk_n++;
                        m_timer = DIV - 1;
                        if (m_state[5:0] == m_cursor) m_walking = 0;
                        else if (m_walk_n == LIMIT) begin m_walking = 0; m_blocked = 1; end
                    end else begin
                        m_walking = 0;
                        m_blocked = 1;
                    end
                end else begin
                    m_timer--;
                end
            end else if (click_valid && mready && legal_target(click_pos, m_state[5:0])) begin
                m_cursor = click_pos;
                m_timer = DIV - 1;
                m_walk_n = 0;
                m_walking = 1;
            end
        end
        m_valid = 1;
    end

    task automatic checkOutput(input string name, input logic [133:0] act, input logic [133:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Compare every DUT output against the reference on each falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("game_state", game_state, m_state);
            checkOutput("mv_state", mv_state, m_state);
            checkOutput("mv_cursor", 134'(mv_cursor), 134'(m_cursor));
            checkOutput("busy", 134'(busy), 134'(m_walking));
            checkOutput("blocked", 134'(blocked), 134'(m_blocked));
            checkOutput("win", 134'(win), 134'(model_win()));
            checkOutput("click_ready", 134'(click_ready),
                        134'(m_loaded && !m_walking && !m_won && !model_win()));
            checkOutput("step_count", 134'(step_count), 134'(m_steps));
        end
    end

    task automatic applyStimulus(input bit do_rst, input bit do_load, input logic [133:0] st,
                                 input logic [63:0] gl, input bit cv, input logic [5:0] cp);
        rst = do_rst; load = do_load; level_state = st; level_goal = gl;
        click_valid = cv; click_pos = cp;
        @(posedge clk);
        #1;
        rst = 1'b0; load = 1'b0; click_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle(input int max_cycles);
        bit ok;
        ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (!busy) begin ok = 1; break; end
            idle(1);
        end
        checkOutput("walk_end_timeout", 134'(ok), 134'(1));
    endtask

    logic [133:0] lvl_row, lvl_wall, lvl_push, lvl_osc, st;
    logic [63:0]  gl, bx;
    logic [5:0]   man, pos;
    int           r;

    initial begin
        rst = 1'b1; load = 1'b0; level_state = '0; level_goal = '0;
        click_valid = 1'b0; click_pos = '0;
        lvl_row  = {cells(1, 1, 4), 64'd0, 6'o11};
        lvl_wall = {cells(1, 1, 1) | cells(1, 3, 3), 64'd0, 6'o11};
        lvl_push = {cells(1, 1, 4), cells(1, 2, 2), 6'o11};
        lvl_osc  = {cells(2, 1, 6), 64'd0, 6'o22};
        idle(2);
        rst = 1'b0;

        checkOutput("reset_state", game_state, 134'd0);
        checkOutput("reset_ready", 134'(click_ready), 134'(0));
        checkOutput("reset_steps", 134'(step_count), 134'(0));

        // open row walk, with a click in the load cycle that must be dropped
        applyStimulus(0, 1, lvl_row, 64'd0, 1, 6'o14);
        checkOutput("load_click_dropped", 134'(busy), 134'(0));
        checkOutput("load_ready", 134'(click_ready), 134'(1));
        applyStimulus(0, 0, '0, '0, 1, 6'o14);
        checkOutput("walk_busy", 134'(busy), 134'(1));
        idle(3);
        checkOutput("step1_not_yet", 134'(game_state[5:0]), 134'(6'o11));
        idle(1);
        checkOutput("step1_man", 134'(game_state[5:0]), 134'(6'o12));
        idle(4);
        checkOutput("step2_man", 134'(game_state[5:0]), 134'(6'o13));
        idle(4);
        checkOutput("step3_man", 134'(game_state[5:0]), 134'(6'o14));
        checkOutput("walk_done_busy", 134'(busy), 134'(0));
        checkOutput("walk_done_steps", 134'(step_count), 134'(3));
        checkOutput("walk_done_blocked", 134'(blocked), 134'(0));

        // wall next to the man
        applyStimulus(0, 1, lvl_wall, 64'd0, 0, '0);
        applyStimulus(0, 0, '0, '0, 1, 6'o13);
        idle(4);
        checkOutput("wall_blocked", 134'(blocked), 134'(1));
        checkOutput("wall_state", game_state, lvl_wall);
        checkOutput("wall_steps", 134'(step_count), 134'(0));
        idle(1);
        checkOutput("wall_pulse_end", 134'(blocked), 134'(0));

        // ignored clicks: border cells and the man's own cell
        applyStimulus(0, 0, '0, '0, 1, 6'o07);
        checkOutput("click_o07", 134'(busy), 134'(0));
        applyStimulus(0, 0, '0, '0, 1, 6'o70);
        checkOutput("click_o70", 134'(busy), 134'(0));
        applyStimulus(0, 0, '0, '0, 1, 6'o11);
        checkOutput("click_self", 134'(busy), 134'(0));

        // push the only box onto its goal
        applyStimulus(0, 1, lvl_push, cells(1, 3, 3), 0, '0);
        applyStimulus(0, 0, '0, '0, 1, 6'o14);
        idle(4);
        checkOutput("win_rise", 134'(win), 134'(1));
        idle(1);
        checkOutput("win_walk_ends", 134'(busy), 134'(0));
        checkOutput("win_ready", 134'(click_ready), 134'(0));
        applyStimulus(0, 0, '0, '0, 1, 6'o14);
        idle(6);
        checkOutput("win_click_ignored", 134'(game_state[5:0]), 134'(6'o12));
        applyStimulus(0, 1, lvl_row, 64'd0, 0, '0);
        checkOutput("reload_win", 134'(win), 134'(0));
        checkOutput("reload_steps", 134'(step_count), 134'(0));

        // load in the middle of a walk
        applyStimulus(0, 0, '0, '0, 1, 6'o14);
        idle(8);
        checkOutput("mid_steps", 134'(step_count), 134'(2));
        applyStimulus(0, 1, lvl_wall, 64'd0, 0, '0);
        checkOutput("midload_state", game_state, lvl_wall);
        checkOutput("midload_busy", 134'(busy), 134'(0));

        // reset in the middle of a walk
        applyStimulus(0, 1, lvl_row, 64'd0, 0, '0);
        applyStimulus(0, 0, '0, '0, 1, 6'o14);
        idle(5);
        applyStimulus(1, 0, '0, '0, 0, '0);
        checkOutput("midrst_state", game_state, 134'd0);
        checkOutput("midrst_busy", 134'(busy), 134'(0));
        checkOutput("midrst_cursor", 134'(mv_cursor), 134'(0));

        // oscillating mover: walks hit the step limit, counter saturates
        osc_mode = 1'b1;
        applyStimulus(0, 1, lvl_osc, 64'd0, 0, '0);
        for (int w = 0; w < 17; w++) begin
            applyStimulus(0, 0, '0, '0, 1, 6'o55);
            waitIdle(100);
            checkOutput("osc_blocked", 134'(blocked), 134'(1));
            if (w == 0) checkOutput("osc_limit_steps", 134'(step_count), 134'(16));
        end
        checkOutput("osc_saturated", 134'(step_count), 134'(8'hFF));
        osc_mode = 1'b0;

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                applyStimulus(1, 0, '0, '0, 0, '0);
            end else if (r < 25) begin
                osc_mode = ($urandom_range(0, 3) == 0);
                man = {3'($urandom_range(1, 6)), 3'($urandom_range(1, 6))};
                bx  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                bx[man] = 1'b0;
                gl  = ($urandom_range(0, 7) == 0) ? bx : ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
                st  = {{$urandom, $urandom} | {$urandom, $urandom}, bx, man};
                applyStimulus(0, 1, st, gl, 1'($urandom_range(0, 1)), 6'($urandom));
            end else begin
                pos = game_state[5:0];
                if ($urandom_range(0, 2) == 0) pos = 6'($urandom);
                else if ($urandom_range(0, 1) == 0) pos[2:0] = 3'($urandom_range(1, 6));
                else pos[5:3] = 3'($urandom_range(1, 6));
                applyStimulus(0, 0, '0, '0, ($urandom_range(0, 2) == 0), pos);
            end
        end

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/game_walk_ctrl.md
Name: game_walk_ctrl

Overview:
- Sequential controller directly upstream of the combinational single-step mover.
- Holds the registered game state {way[63:0], box[63:0], man[5:0]}, accepts cursor clicks, and drives the mover one step at a time toward the clicked cell.
- Commits each accepted step, counts moves, detects blocking and detects a win.
- Sits between input handling (mouse/keys) and the renderer, which reads game_state.

Parameters:
- STEP_DIV, 4: clock cycles per committed step (animation pacing); legal range ≥1.
- WALK_LIMIT, 16: maximum steps per click before the walk aborts.
- STEP_W, 16: width of the move counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  level load strobe
- level_state  in  134  initial {way, box, man}; man = {y[2:0], x[2:0]}; cell index = {y, x}
- level_goal  in  64  goal-cell mask
- click_valid  in  1  click request
- click_pos  in  6  clicked cell {y, x}
- click_ready  out  1  controller can accept a click
- mv_state  out  134  state presented to the mover (equals game_state)
- mv_cursor  out  6  latched target presented to the mover
- mv_next  in  134  mover's proposed next state
- mv_result  in  1  mover: step legal
- game_state  out  134  committed state
- busy  out  1  walk in progress
- blocked  out  1  one-cycle pulse when a walk stops without reaching target
- win  out  1  level solved (level signal)
- step_count  out  STEP_W  total committed steps since load

Behaviour:
- Reset (sync, active-high, highest priority):
  - game_state = 0, goal = 0, cursor = 0, step_count = 0, walk counter = 0, pace timer = 0.
  - FSM = IDLE; busy = 0, blocked = 0, win = 0, click_ready = 0 until the first load.
  - rst asserted mid-walk aborts the walk immediately.
- load (priority over everything except rst), accepted in any state:
  - game_state ← level_state, goal ← level_goal, step_count ← 0, FSM ← IDLE.
  - The loaded flag is set, enabling clicks.
  - A click presented in the same cycle as load is dropped.
- FSM states: IDLE, WALK, WIN.
- IDLE:
  - click_ready = loaded flag.
  - A handshake is click_valid & click_ready.
  - The click is ignored (no state change, no blocked pulse) when click_pos == man, or when either coordinate of click_pos is 0 or 7. The mover does not check boundaries.
  - Otherwise: cursor ← click_pos, pace timer ← STEP_DIV−1, walk counter ← 0, FSM ← WALK, busy = 1 from the next cycle.
- WALK:
  - click_ready = 0; clicks are not queued.
  - The pace timer decrements each cycle. When it reaches 0, the step is evaluated on the current mv_next/mv_result:
    - mv_result=1: game_state ← mv_next; step_count ← step_count+1, saturating at all-ones; walk counter +1; pace timer reloads STEP_DIV−1.
    - mv_result=0: FSM ← IDLE, blocked pulses for 1 cycle, and game_state is unchanged.
  - After a commit:
    - If the new man == cursor: FSM ← IDLE, no blocked pulse.
    - Else if the walk counter reaches WALK_LIMIT: FSM ← IDLE and blocked pulses.
- Win check:
  - Evaluated combinationally on the committed state: win = loaded & (box == goal) & (goal != 0).
  - When win rises, FSM ← WIN on the next cycle, including in the middle of a walk; the walk ends.
- WIN: click_ready = 0, busy = 0; the FSM leaves WIN only on load or rst.
- Latency:
  - The first step commits STEP_DIV cycles after the click handshake.
  - Later steps commit every STEP_DIV cycles.
- mv_state and mv_cursor are direct register outputs, so the mover sees a stable input for the whole pace interval.

Decomposition:
- Shared package holds:
  - Field slices: WAY_MSB = 133, WAY_LSB = 70, BOX_MSB = 69, BOX_LSB = 6, MAN_W = 6, STATE_W = 134.
  - Border coordinates 0 and 7.
  - FSM state encodings.
- One natural sub-module: game_pace_timer, the STEP_DIV down-counter with reload and tick output.
- The mover stays external and is instantiated alongside at top level.

Test Plan:
- Reset, then load with man=6'o11 and an empty path to cursor 6'o14 (row 1, cols 1→4 open). Expected: busy goes 1, man becomes 6'o12 / 6'o13 / 6'o14 at handshake+4/8/12 cycles, then IDLE with step_count=3 and no blocked pulse.
- Wall adjacent to the man, so the mover returns mv_result=0 on the first evaluation. Expected: blocked pulses once at handshake+4, game_state unchanged, step_count=0, FSM returns to IDLE.
- Click on 6'o07, 6'o70 or on the man's own cell. Expected: no busy, no blocked, state unchanged.
- Last box pushed onto its goal (box == goal). Expected: win=1 within 1 cycle of the commit, FSM=WIN, and further clicks are ignored. A later load clears win and resets step_count to 0.
- Assert load at walk step 2 with a new level. Expected: game_state equals the new level the next cycle, busy=0, step_count=0. Separately, rst mid-walk zeroes all outputs.
- Mover model that oscillates (never reaches cursor). Expected: walk aborts after exactly 16 commits with a blocked pulse. With step_count preset near 16'hFFFF, the counter saturates at 16'hFFFF.
